// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the pipeline's memory-access unit (master)
// and the data memory (slave).
interface mem_access_unit_if;
  logic [31:0] DMEM_ADDR;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [3:0]  DMEM_BYTE_EN;
  logic [31:0] DMEM_WDATA;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_READY;

  modport master (
    output DMEM_ADDR, DMEM_READ, DMEM_WRITE, DMEM_BYTE_EN, DMEM_WDATA,
    input  DMEM_RDATA, DMEM_READY
  );

  modport slave (
    input  DMEM_ADDR, DMEM_READ, DMEM_WRITE, DMEM_BYTE_EN, DMEM_WDATA,
    output DMEM_RDATA, DMEM_READY
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks alignment, lane-aligns stores, stalls the
// pipeline while data memory responds, and formats load results.
module mem_access_unit (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      MEM_READ_EN,
  input  logic                      MEM_WRITE_EN,
  input  logic [2:0]                MEM_FUNCT3,
  input  logic [31:0]               MEM_ALU_OUT,
  input  logic [31:0]               MEM_WRITE_DATA,
  output logic [31:0]               MEM_DATA_MEM_READ_DATA,
  output logic                      MEM_BUSY,
  output logic                      MEM_FAULT,
  mem_access_unit_if.master         dmem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_req, w_is_read, w_illegal, w_misaligned, w_legal;
  logic        w_start, w_fault, w_access;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata;

  logic [31:0] r_addr;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;
  logic        r_is_read;
  logic [3:0]  r_byte_en;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic [7:0]  w_rbyte [4];
  logic [7:0]  w_sel_byte;
  logic [15:0] w_sel_half;
  logic [31:0] w_load_data;

  // A request seen while reset is asserted never starts or faults.
  assign w_req     = RESET & (MEM_READ_EN | MEM_WRITE_EN);
  assign w_is_read = MEM_READ_EN;

  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (w_is_read)
      w_illegal = (MEM_FUNCT3 == 3'b011) || (MEM_FUNCT3[2:1] == 2'b11);
    else
      w_illegal = MEM_FUNCT3[2] || (MEM_FUNCT3[1:0] == 2'b11);
    w_misaligned = ((MEM_FUNCT3[1:0] == 2'b01) && MEM_ALU_OUT[0]) ||
                   ((MEM_FUNCT3[1:0] == 2'b10) && (MEM_ALU_OUT[1:0] != 2'b00));
  end
  assign w_legal = !w_illegal && !w_misaligned;

  always_comb begin
    w_byte_en = 4'b1111;
    w_wdata   = MEM_WRITE_DATA;
    case (MEM_FUNCT3[1:0])
      2'b00: begin
        w_byte_en = 4'b0001 << MEM_ALU_OUT[1:0];
        w_wdata   = {4{MEM_WRITE_DATA[7:0]}};
      end
      2'b01: begin
        w_byte_en = 4'b0011 << {MEM_ALU_OUT[1], 1'b0};
        w_wdata   = {2{MEM_WRITE_DATA[15:0]}};
      end
      default: ;
    endcase
    if (w_is_read)
      w_wdata = 32'd0;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_fault      = 1'b0;
    MEM_BUSY     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_legal) begin
            w_start      = 1'b1;
            MEM_BUSY     = 1'b1;
            w_state_next = ACCESS;
          end else begin
            w_fault = 1'b1;
          end
        end
      end
      ACCESS: begin
        MEM_BUSY = 1'b1;
        if (dmem.DMEM_READY)
          w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_addr    <= 32'd0;
      r_lane    <= 2'd0;
      r_funct3  <= 3'd0;
      r_is_read <= 1'b0;
      r_byte_en <= 4'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
    end else begin
      if (w_start) begin
        r_addr    <= {MEM_ALU_OUT[31:2], 2'b00};
        r_lane    <= MEM_ALU_OUT[1:0];
        r_funct3  <= MEM_FUNCT3;
        r_is_read <= w_is_read;
        r_byte_en <= w_byte_en;
        r_wdata   <= w_wdata;
      end
      // Stores leave the last load result in place.
      if (r_state == ACCESS && dmem.DMEM_READY && r_is_read)
        r_rdata <= w_load_data;
      else if (w_fault)
        r_rdata <= 32'd0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_rbyte[gi] = dmem.DMEM_RDATA[8*gi +: 8];
    end
  endgenerate

  assign w_sel_byte = w_rbyte[r_lane];
  assign w_sel_half = {w_rbyte[{r_lane[1], 1'b1}], w_rbyte[{r_lane[1], 1'b0}]};

  always_comb begin
    w_load_data = dmem.DMEM_RDATA;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_sel_byte[7]}}, w_sel_byte};
      3'b001:  w_load_data = {{16{w_sel_half[15]}}, w_sel_half};
      3'b100:  w_load_data = {24'd0, w_sel_byte};
      3'b101:  w_load_data = {16'd0, w_sel_half};
      default: w_load_data = dmem.DMEM_RDATA;
    endcase
  end

  assign w_access          = (r_state == ACCESS);
  assign dmem.DMEM_READ    = w_access & r_is_read;
  assign dmem.DMEM_WRITE   = w_access & ~r_is_read;
  assign dmem.DMEM_ADDR    = w_access ? r_addr : 32'd0;
  assign dmem.DMEM_BYTE_EN = w_access ? r_byte_en : 4'd0;
  assign dmem.DMEM_WDATA   = w_access ? r_wdata : 32'd0;

  assign MEM_FAULT              = w_fault;
  assign MEM_DATA_MEM_READ_DATA = w_fault ? 32'd0 : r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the bench acts as data memory, checks
// each bus access and each completed/faulted transaction against queued values.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [2:0]  f3;
  logic [31:0] addr, wd;
  logic [31:0] rdata_out;
  logic        busy, fault;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .CLK                    (clk),
    .RESET                  (rst_n),
    .MEM_READ_EN            (rd_en),
    .MEM_WRITE_EN           (wr_en),
    .MEM_FUNCT3             (f3),
    .MEM_ALU_OUT            (addr),
    .MEM_WRITE_DATA         (wd),
    .MEM_DATA_MEM_READ_DATA (rdata_out),
    .MEM_BUSY               (busy),
    .MEM_FAULT              (fault),
    .dmem                   (bus)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        flt;
    logic [31:0] data;
    int          busy_len;
  } resp_t;

  acc_t        exp_acc[$];
  resp_t       exp_resp[$];
  int          total = 0;
  int          bad = 0;
  int          ready_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] mem_word = 32'd0;
  bit          mon_en = 1'b0;
  acc_t        m_got, m_exp;
  resp_t       r_exp;
  logic        prev_busy = 1'b0;
  int          busy_len = 0;

  // Memory model plus bus-side scoreboard.
  always @(negedge clk) begin
    if (bus.DMEM_READ || bus.DMEM_WRITE) begin
      if (wait_cnt == 0) begin
        m_got = {bus.DMEM_READ, bus.DMEM_WRITE, bus.DMEM_BYTE_EN, bus.DMEM_ADDR, bus.DMEM_WDATA};
        total++;
        if (exp_acc.size() == 0) begin
          bad++;
          $display("FAIL bus_access: unexpected access got=%h", m_got);
        end else begin
          m_exp = exp_acc.pop_front();
          if (m_got !== m_exp) begin
            bad++;
            $display("FAIL bus_access: got rd=%b wr=%b be=%b addr=%h wdata=%h want rd=%b wr=%b be=%b addr=%h wdata=%h",
                     m_got.rd, m_got.wr, m_got.be, m_got.addr, m_got.wdata,
                     m_exp.rd, m_exp.wr, m_exp.be, m_exp.addr, m_exp.wdata);
          end else
            $display("ok   bus_access rd=%b wr=%b be=%b addr=%h wdata=%h",
                     m_got.rd, m_got.wr, m_got.be, m_got.addr, m_got.wdata);
        end
      end
      bus.DMEM_RDATA = mem_word;
      bus.DMEM_READY = (wait_cnt >= ready_delay);
      wait_cnt++;
    end else begin
      bus.DMEM_READY = 1'b0;
      bus.DMEM_RDATA = 32'd0;
      wait_cnt = 0;
    end
  end

  // Pipeline-side monitor: completion = falling MEM_BUSY, fault = MEM_FAULT.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (fault) begin
        total++;
        if (exp_resp.size() == 0) begin
          bad++;
          $display("FAIL fault: unexpected fault pulse");
        end else begin
          r_exp = exp_resp.pop_front();
          if (!r_exp.flt || rdata_out !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fault: got fault=1 data=%h busy=%b want fault=%b data=0 busy=0",
                     rdata_out, busy, r_exp.flt);
          end else
            $display("ok   fault pulse data=%h busy=%b", rdata_out, busy);
        end
      end else if (prev_busy && !busy) begin
        total++;
        if (exp_resp.size() == 0) begin
          bad++;
          $display("FAIL complete: unexpected completion data=%h", rdata_out);
        end else begin
          r_exp = exp_resp.pop_front();
          if (r_exp.flt || rdata_out !== r_exp.data || busy_len != r_exp.busy_len) begin
            bad++;
            $display("FAIL complete: got data=%h busy_cycles=%0d want fault=%b data=%h busy_cycles=%0d",
                     rdata_out, busy_len, r_exp.flt, r_exp.data, r_exp.busy_len);
          end else
            $display("ok   complete data=%h busy_cycles=%0d", rdata_out, busy_len);
        end
      end
      if (busy) busy_len++;
      else busy_len = 0;
      prev_busy = busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end else
      $display("ok   %s = %h", name, got);
  endtask

  task automatic expect_acc(input logic r, input logic w, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] d);
    exp_acc.push_back({r, w, be, a, d});
  endtask

  task automatic expect_resp(input logic flt, input logic [31:0] d, input int bl);
    resp_t e;
    e.flt = flt; e.data = d; e.busy_len = bl;
    exp_resp.push_back(e);
  endtask

  task automatic issue(input logic r, input logic w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] mw, input int dly, input bit hold);
    int n;
    @(posedge clk); #1;
    rd_en = r; wr_en = w; f3 = fn; addr = a; wd = d;
    mem_word = mw; ready_delay = dly;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 30);
    if (busy) begin
      total++; bad++;
      $display("FAIL timeout: busy=%b after %0d cycles want busy=0", busy, n);
    end
    if (hold) begin
      @(posedge clk); #1;
    end
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; f3 = 3'd0; addr = 32'd0; wd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata_out, 32'd0);
    chk("reset_busy_fault", {30'd0, busy, fault}, 32'd0);
    chk("reset_strobes", {26'd0, bus.DMEM_READ, bus.DMEM_WRITE, bus.DMEM_BYTE_EN}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    expect_acc(1, 0, 4'b1111, 32'h10, 32'h0); expect_resp(0, 32'hDEADBEEF, 3);
    issue(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0);
    expect_acc(1, 0, 4'b1000, 32'h10, 32'h0); expect_resp(0, 32'hFFFFFF80, 2);
    issue(1, 0, 3'b000, 32'h13, 32'h0, 32'h80112233, 0, 0);
    expect_acc(1, 0, 4'b1000, 32'h10, 32'h0); expect_resp(0, 32'h00000080, 2);
    issue(1, 0, 3'b100, 32'h13, 32'h0, 32'h80112233, 0, 0);
    expect_acc(0, 1, 4'b1100, 32'h20, 32'hABCDABCD); expect_resp(0, 32'h00000080, 4);
    issue(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 2, 0);
    expect_resp(1, 32'h0, 0);
    issue(1, 0, 3'b010, 32'h06, 32'h0, 32'h0, 0, 0);
    expect_acc(1, 0, 4'b1111, 32'h40, 32'h0); expect_resp(0, 32'h12345678, 2);
    issue(1, 1, 3'b010, 32'h40, 32'hFFFFFFFF, 32'h12345678, 0, 0);
    expect_acc(1, 0, 4'b1100, 32'h40, 32'h0); expect_resp(0, 32'hFFFF8001, 2);
    issue(1, 0, 3'b001, 32'h42, 32'h0, 32'h80017FFF, 0, 0);
    expect_acc(1, 0, 4'b1100, 32'h40, 32'h0); expect_resp(0, 32'h00008001, 2);
    issue(1, 0, 3'b101, 32'h42, 32'h0, 32'h80017FFF, 0, 0);
    expect_acc(1, 0, 4'b0011, 32'h40, 32'h0); expect_resp(0, 32'h00007FFF, 2);
    issue(1, 0, 3'b001, 32'h40, 32'h0, 32'h80017FFF, 0, 0);
    expect_acc(0, 1, 4'b0010, 32'h40, 32'h5A5A5A5A); expect_resp(0, 32'h00007FFF, 2);
    issue(0, 1, 3'b000, 32'h41, 32'h1234565A, 32'h0, 0, 1);
    expect_resp(1, 32'h0, 0);
    issue(1, 0, 3'b011, 32'h00, 32'h0, 32'h0, 0, 0);
    expect_resp(1, 32'h0, 0);
    issue(0, 1, 3'b100, 32'h00, 32'h0, 32'h0, 0, 0);
    expect_resp(1, 32'h0, 0);
    issue(0, 1, 3'b001, 32'h23, 32'h0, 32'h0, 0, 0);
    expect_resp(1, 32'h0, 0);
    issue(0, 1, 3'b010, 32'h02, 32'h0, 32'h0, 0, 0);
    expect_acc(0, 1, 4'b1111, 32'h04, 32'hCAFEF00D); expect_resp(0, 32'h0, 2);
    issue(0, 1, 3'b010, 32'h04, 32'hCAFEF00D, 32'h0, 0, 0);
    expect_acc(1, 0, 4'b0001, 32'h10, 32'h0); expect_resp(0, 32'h0000007F, 2);
    issue(1, 0, 3'b000, 32'h10, 32'h0, 32'h0000007F, 0, 1);

    // Reset in the second ACCESS cycle while memory never answers.
    @(posedge clk); #1;
    mon_en = 1'b0;
    expect_acc(1, 0, 4'b1111, 32'h50, 32'h0);
    rd_en = 1'b1; f3 = 3'b010; addr = 32'h50; ready_delay = 1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_pre_busy_read", {30'd0, busy, bus.DMEM_READ}, 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_fault", {30'd0, busy, fault}, 32'd0);
    chk("abort_strobes", {26'd0, bus.DMEM_READ, bus.DMEM_WRITE, bus.DMEM_BYTE_EN}, 32'd0);
    chk("abort_rdata", rdata_out, 32'd0);
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_retry", {30'd0, busy, bus.DMEM_READ}, 32'd0);
    mon_en = 1'b1;

    expect_acc(1, 0, 4'b0010, 32'h10, 32'h0); expect_resp(0, 32'h000000C3, 2);
    issue(1, 0, 3'b100, 32'h11, 32'h0, 32'h0000C300, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("acc_queue_left", exp_acc.size(), 32'd0);
    chk("resp_queue_left", exp_resp.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
